// File: rtl/controller.sv
// controller: multi-cycle Moore FSM sequencer for the 8-bit stack CPU.
// Decodes the IR opcode and drives every datapath control input. Control
// outputs are registered: each one is decoded from the next state, so it
// changes together with `state`.
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-low reset
//   opcode[2:0]       - instruction[7:5] from IR
//   IR_write, ld_A, ld_B                  - register load enables
//   IorD, MtoS, src_A, src_B, pc_src      - datapath mux selects
//   mem_read, mem_write                   - memory strobes
//   pc_write, pc_write_cond               - PC load enables
//   alu_op[1:0]       - 00 add, 01 sub, 10 and, 11 not
//   push, pop, tos    - stack controls
//   state[3:0]        - current FSM state (debug)
module controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  output logic       IR_write,
  output logic       ld_A,
  output logic       ld_B,
  output logic       IorD,
  output logic       MtoS,
  output logic       src_A,
  output logic       src_B,
  output logic       pc_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] alu_op,
  output logic       push,
  output logic       pop,
  output logic       tos,
  output logic [3:0] state
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned ALU_OP_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_POP1  = 4'd2,
    S_POP2  = 4'd3,
    S_LDA   = 4'd4,
    S_LDB   = 4'd5,
    S_ALU   = 4'd6,
    S_PUSHR = 4'd7,
    S_MRD   = 4'd8,
    S_PUSHM = 4'd9,
    S_MWR   = 4'd10,
    S_JMP   = 4'd11,
    S_TOS   = 4'd12,
    S_ZW    = 4'd13,
    S_BR    = 4'd14,
    S_ILL   = 4'd15
  } state_t;

  typedef struct packed {
    logic                ir_write;
    logic                ld_a;
    logic                ld_b;
    logic                iord;
    logic                mtos;
    logic                src_a;
    logic                src_b;
    logic                pc_src;
    logic                mem_read;
    logic                mem_write;
    logic                pc_write;
    logic                pc_write_cond;
    logic [ALU_OP_W-1:0] alu_op;
    logic                push;
    logic                pop;
    logic                tos;
  } ctrl_t;

  localparam ctrl_t CTRL_IF = '{ir_write: 1'b1, iord: 1'b1, mem_read: 1'b1,
                                pc_src: 1'b1, pc_write: 1'b1, default: '0};

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;

  // Moore output decode for a given state; alu_op follows the latched opcode.
  function automatic ctrl_t decode(input state_t s, input logic [ALU_OP_W-1:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_IF:    c = CTRL_IF;
      S_POP1:  c.pop = 1'b1;
      S_POP2:  begin c.pop = 1'b1; c.ld_a = 1'b1; end
      S_LDA:   c.ld_a = 1'b1;
      S_LDB:   c.ld_b = 1'b1;
      S_ALU:   begin c.src_a = 1'b1; c.src_b = 1'b1; c.alu_op = op; end
      S_PUSHR: begin c.mtos = 1'b1; c.push = 1'b1; end
      S_MRD:   c.mem_read = 1'b1;
      S_PUSHM: c.push = 1'b1;
      S_MWR:   c.mem_write = 1'b1;
      S_JMP:   c.pc_write = 1'b1;
      S_TOS:   c.tos = 1'b1;
      S_BR:    c.pc_write_cond = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // State and output registers; reset forces IF and its outputs immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IF;
      ctrl_q  <= CTRL_IF;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Next-state logic plus the output decode of the state being entered.
  always_comb begin
    state_d = S_IF;
    ctrl_d  = '0;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (!opcode[2]) begin
          state_d = S_POP1;
        end else begin
          case (opcode[1:0])
            2'b00:   state_d = S_MRD;
            2'b01:   state_d = S_POP1;
            2'b10:   state_d = S_JMP;
            default: state_d = S_TOS;
          endcase
        end
      end
      // NOT and POP need only one operand; binary ops pop a second.
      S_POP1:  state_d = (opcode == 3'b011 || opcode == 3'b101) ? S_LDA : S_POP2;
      S_POP2:  state_d = S_LDB;
      S_LDA:   state_d = opcode[2] ? S_MWR : S_ALU;
      S_LDB:   state_d = S_ALU;
      S_ALU:   state_d = S_PUSHR;
      S_PUSHR: state_d = S_IF;
      S_MRD:   state_d = S_PUSHM;
      S_PUSHM: state_d = S_IF;
      S_MWR:   state_d = S_IF;
      S_JMP:   state_d = S_IF;
      S_TOS:   state_d = S_ZW;
      S_ZW:    state_d = S_BR;
      S_BR:    state_d = S_IF;
      default: state_d = S_IF;
    endcase
    ctrl_d = decode(state_d, opcode[1:0]);
  end

  assign state         = state_q;
  assign IR_write      = ctrl_q.ir_write;
  assign ld_A          = ctrl_q.ld_a;
  assign ld_B          = ctrl_q.ld_b;
  assign IorD          = ctrl_q.iord;
  assign MtoS          = ctrl_q.mtos;
  assign src_A         = ctrl_q.src_a;
  assign src_B         = ctrl_q.src_b;
  assign pc_src        = ctrl_q.pc_src;
  assign mem_read      = ctrl_q.mem_read;
  assign mem_write     = ctrl_q.mem_write;
  assign pc_write      = ctrl_q.pc_write;
  assign pc_write_cond = ctrl_q.pc_write_cond;
  assign alu_op        = ctrl_q.alu_op;
  assign push          = ctrl_q.push;
  assign pop           = ctrl_q.pop;
  assign tos           = ctrl_q.tos;

endmodule
